// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl
//   Parallel-in / serial-out shifter with a valid/ready load handshake.
//   A WIDTH-bit word is captured on accept. It is then sent one bit per
//   cycle in which shift_en is high. The next word can be accepted in the
//   same cycle as the last bit, so back-to-back words form a gapless stream.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: send bit WIDTH-1 first, 0: send bit 0 first
//   IDLE_LEVEL level driven on serial_out while no frame is active
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   load_valid   parallel_in holds a word to send
//   load_ready   a word can be accepted this cycle
//   parallel_in  word to serialise, captured only on accept
//   shift_en     bit-rate strobe; the current bit advances when high
//   serial_out   current serial bit, IDLE_LEVEL when not busy
//   serial_valid serial_out carries frame data
//   frame_start  current bit is the first bit of the frame
//   frame_end    current bit is the last bit of the frame
//   busy         frame in progress (same as serial_valid)
module piso_shift_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_head;

  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
  // The ready term is gated by rst so that no word is accepted while the
  // block is held in reset.
  assign load_ready = rst && ((r_state == IDLE) || (w_last && shift_en));
  assign w_accept   = load_valid && load_ready;

  assign w_head = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    // An accept in SHIFT can only happen on the last bit with shift_en
    // high, so it also closes the current frame.
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shreg_nxt = parallel_in;
      w_cnt_nxt   = '0;
    end else if ((r_state == SHIFT) && shift_en) begin
      if (r_cnt == LAST) begin
        w_state_nxt = IDLE;
      end else begin
        w_shreg_nxt = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

  assign serial_valid = (r_state == SHIFT);
  assign busy         = serial_valid;
  assign serial_out   = serial_valid ? w_head : IDLE_LEVEL;
  assign frame_start  = (r_state == SHIFT) && (r_cnt == '0);
  assign frame_end    = w_last;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
module tb_piso_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WIDTH=8 MSB first idle 0; 1: WIDTH=3 LSB first idle 0;
  // 2: WIDTH=8 MSB first idle 1.
  logic       rst_v [3];
  logic       lv_v  [3];
  logic       se_v  [3];
  logic [7:0] din_v [3];
  logic       rdy_v [3];
  logic       so_v  [3];
  logic       sv_v  [3];
  logic       fs_v  [3];
  logic       fe_v  [3];
  logic       bsy_v [3];

  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst_v[0]), .load_valid(lv_v[0]), .load_ready(rdy_v[0]),
    .parallel_in(din_v[0]), .shift_en(se_v[0]), .serial_out(so_v[0]),
    .serial_valid(sv_v[0]), .frame_start(fs_v[0]), .frame_end(fe_v[0]),
    .busy(bsy_v[0]));

  piso_shift_ctrl #(.WIDTH(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst_v[1]), .load_valid(lv_v[1]), .load_ready(rdy_v[1]),
    .parallel_in(din_v[1][2:0]), .shift_en(se_v[1]), .serial_out(so_v[1]),
    .serial_valid(sv_v[1]), .frame_start(fs_v[1]), .frame_end(fe_v[1]),
    .busy(bsy_v[1]));

  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_c (
    .clk(clk), .rst(rst_v[2]), .load_valid(lv_v[2]), .load_ready(rdy_v[2]),
    .parallel_in(din_v[2]), .shift_en(se_v[2]), .serial_out(so_v[2]),
    .serial_valid(sv_v[2]), .frame_start(fs_v[2]), .frame_end(fe_v[2]),
    .busy(bsy_v[2]));

  int   n_checks = 0;
  int   n_fail   = 0;

  // Scoreboard: bits of every accepted word, in transmission order.
  logic q_bits[$];
  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  int   sv_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on DUT s: drive inputs, check outputs mid-cycle,
  // update the scoreboard with what the coming edge should do.
  task automatic cyc(input int s, input logic r, input logic lv,
                     input logic [7:0] din, input logic se);
    int   w;
    bit   msb;
    logic idl;
    logic exp_rdy;
    logic exp_so;
    w   = (s == 1) ? 3 : 8;
    msb = (s != 1);
    idl = (s == 2);
    rst_v[s] = r; lv_v[s] = lv; din_v[s] = din; se_v[s] = se;
    @(negedge clk);
    exp_rdy = r && (!m_busy || ((m_cnt == w - 1) && se));
    exp_so  = (m_busy && q_bits.size() > 0) ? q_bits[0] : idl;
    chk("load_ready",   32'(rdy_v[s]), 32'(exp_rdy));
    chk("serial_valid", 32'(sv_v[s]),  32'(m_busy));
    chk("busy",         32'(bsy_v[s]), 32'(m_busy));
    chk("serial_out",   32'(so_v[s]),  32'(exp_so));
    chk("frame_start",  32'(fs_v[s]),  32'(m_busy && m_cnt == 0));
    chk("frame_end",    32'(fe_v[s]),  32'(m_busy && m_cnt == w - 1));
    if (sv_v[s]) sv_seen++;
    if (!r) begin
      m_busy = 1'b0; m_cnt = 0; q_bits.delete();
    end else begin
      if (m_busy && se) begin
        if (q_bits.size() > 0) void'(q_bits.pop_front());
        if (m_cnt == w - 1) m_busy = 1'b0;
        else m_cnt++;
      end
      if (lv && exp_rdy) begin
        for (int i = 0; i < w; i++)
          q_bits.push_back(msb ? din[w-1-i] : din[i]);
        m_busy = 1'b1; m_cnt = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0; lv_v[i] = 1'b0; se_v[i] = 1'b0; din_v[i] = 8'h00;
    end
    @(posedge clk); #1;

    // Reset behaviour on DUT A: ready low while in reset, idle afterwards.
    cyc(0, 1'b0, 1'b1, 8'h55, 1'b1);
    cyc(0, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Single word A5 with constant shift_en, then idle.
    cyc(0, 1'b1, 1'b1, 8'hA5, 1'b1);
    for (int k = 0; k < 10; k++) cyc(0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Back-to-back A5 then 3C with load_valid held high.
    cyc(0, 1'b1, 1'b1, 8'hA5, 1'b1);
    for (int k = 1; k <= 8; k++) cyc(0, 1'b1, 1'b1, 8'h3C, 1'b1);
    for (int k = 0; k < 9; k++) cyc(0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("q_empty_b2b", 32'(q_bits.size()), 32'd0);

    // Slow strobe: shift_en every third cycle, mid-frame load ignored.
    sv_seen = 0;
    cyc(0, 1'b1, 1'b1, 8'hF0, 1'b0);
    for (int k = 1; k <= 26; k++)
      cyc(0, 1'b1, (k == 5), 8'hFF, (k % 3 == 0));
    chk("busy_cycles_slow", 32'(sv_seen), 32'd24);

    // Reset during the 4th bit, then a clean 81 frame.
    cyc(0, 1'b1, 1'b1, 8'hC3, 1'b1);
    for (int k = 1; k <= 3; k++) cyc(0, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b1, 1'b1, 8'h81, 1'b1);
    for (int k = 0; k < 9; k++) cyc(0, 1'b1, 1'b0, 8'h00, 1'b1);

    // DUT B: WIDTH=3, LSB first, words separated by idle gaps.
    m_busy = 1'b0; m_cnt = 0; q_bits.delete();
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b1, 1'b1, 8'h01, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b1, 1'b1, 8'h04, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b1, 1'b1, 8'h05, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1, 1'b1, 1'b0, 8'h00, 1'b1);

    // DUT C: idle level 1, all-zero word.
    m_busy = 1'b0; m_cnt = 0; q_bits.delete();
    cyc(2, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(2, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(2, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc(2, 1'b1, 1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) cyc(2, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
